keccak_arbiter: RTL and testbench

KECCAK_ARBITER -- requirements
Module: keccak_arbiter

---
 rtl/keccak_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_keccak_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter that time-shares one keccak_core between NUM_REQ
// requesters. One job (start, absorb, squeeze, optional stop) runs at a time.
// The owner's sink stream is muxed to the core, and the core's digest is
// routed back to the owner only.

package keccak_pkg;
  localparam int DWIDTH            = 64;
  localparam int KEEP_WIDTH        = 8;
  localparam int MODE_SEL_WIDTH    = 2;
  localparam int MAX_OUTPUT_DWIDTH = 64;
endpackage

// Per-requester handshake gating: only the selected lane sees the core.
module keccak_arb_lane (
  input  logic sel,
  input  logic absorb,
  input  logic squeeze,
  input  logic core_t_ready_i,
  input  logic core_t_valid_i,
  output logic s_t_ready_o,
  output logic m_t_valid_o
);
  assign s_t_ready_o = sel & absorb  & core_t_ready_i;
  assign m_t_valid_o = sel & squeeze & core_t_valid_i;
endmodule

module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int STOP_HOLD = 128,
  localparam int OW = $clog2(NUM_REQ),
  localparam int CW = $clog2(STOP_HOLD + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ*MODE_SEL_WIDTH-1:0]   req_mode_i,
  input  logic [NUM_REQ-1:0]                  req_stop_i,
  output logic [NUM_REQ-1:0]                  grant_o,
  input  logic [NUM_REQ*DWIDTH-1:0]           s_t_data_i,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]       s_t_keep_i,
  input  logic [NUM_REQ-1:0]                  s_t_valid_i,
  input  logic [NUM_REQ-1:0]                  s_t_last_i,
  output logic [NUM_REQ-1:0]                  s_t_ready_o,
  output logic [MAX_OUTPUT_DWIDTH-1:0]        m_t_data_o,
  output logic [KEEP_WIDTH-1:0]               m_t_keep_o,
  output logic                                m_t_last_o,
  output logic [NUM_REQ-1:0]                  m_t_valid_o,
  input  logic [NUM_REQ-1:0]                  m_t_ready_i,
  output logic                                core_start_o,
  output logic [MODE_SEL_WIDTH-1:0]           core_mode_o,
  output logic                                core_stop_o,
  output logic [DWIDTH-1:0]                   core_t_data_o,
  output logic [KEEP_WIDTH-1:0]               core_t_keep_o,
  output logic                                core_t_valid_o,
  output logic                                core_t_last_o,
  input  logic                                core_t_ready_i,
  input  logic [MAX_OUTPUT_DWIDTH-1:0]        core_t_data_i,
  input  logic [KEEP_WIDTH-1:0]               core_t_keep_i,
  input  logic                                core_t_valid_i,
  input  logic                                core_t_last_i,
  output logic                                core_t_ready_o,
  output logic                                busy_o,
  output logic [OW-1:0]                       owner_o
);

  typedef enum logic [2:0] {IDLE, START, ABSORB, SQUEEZE, STOP, RELEASE} state_t;

  state_t                    state_q, state_d;
  logic [OW-1:0]             owner_q, owner_d;
  logic [OW-1:0]             rr_q, rr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [MODE_SEL_WIDTH-1:0] mode_q, mode_d;
  logic                      start_q, start_d;
  logic                      stop_q, stop_d;
  logic                      busy_q, busy_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;

  logic absorb, squeeze;
  assign absorb  = (state_q == ABSORB);
  assign squeeze = (state_q == SQUEEZE);

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    logic found;
    int   idx;
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    found   = 1'b0;
    idx     = 0;
    case (state_q)
      IDLE: begin
        // First set request at or above rr_q, wrapping around.
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (int'(rr_q) + k) % NUM_REQ;
          if (!found && req_i[idx]) begin
            found   = 1'b1;
            owner_d = OW'(idx);
            mode_d  = req_mode_i[idx*MODE_SEL_WIDTH +: MODE_SEL_WIDTH];
            state_d = START;
          end
        end
      end
      START: state_d = ABSORB;
      ABSORB: begin
        if (s_t_valid_i[owner_q] & s_t_last_i[owner_q] & core_t_ready_i)
          state_d = SQUEEZE;
      end
      SQUEEZE: begin
        // Stop wins over a coincident last beat; that beat still passes through.
        if (req_stop_i[owner_q]) begin
          state_d = STOP;
          cnt_d   = CW'(STOP_HOLD - 1);
        end else if (core_t_valid_i & core_t_last_i & m_t_ready_i[owner_q]) begin
          state_d = RELEASE;
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = RELEASE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RELEASE: begin
        rr_d    = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == START);
    stop_d  = (state_d == STOP);
    busy_d  = (state_d != IDLE);
    grant_d = (state_d != IDLE) ? (NUM_REQ'(1) << owner_d) : '0;
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
    end
  end

  assign core_start_o = start_q;
  assign core_stop_o  = stop_q;
  assign core_mode_o  = mode_q;
  assign busy_o       = busy_q;
  assign grant_o      = grant_q;
  assign owner_o      = owner_q;

  // Sink mux toward the core, live only while absorbing.
  always_comb begin
    core_t_data_o  = '0;
    core_t_keep_o  = '0;
    core_t_valid_o = 1'b0;
    core_t_last_o  = 1'b0;
    if (absorb) begin
      core_t_data_o  = s_t_data_i[owner_q*DWIDTH +: DWIDTH];
      core_t_keep_o  = s_t_keep_i[owner_q*KEEP_WIDTH +: KEEP_WIDTH];
      core_t_valid_o = s_t_valid_i[owner_q];
      core_t_last_o  = s_t_last_i[owner_q];
    end
  end

  // Digest broadcast; in STOP the core output is drained and dropped.
  always_comb begin
    m_t_data_o     = '0;
    m_t_keep_o     = '0;
    m_t_last_o     = 1'b0;
    core_t_ready_o = (state_q == STOP);
    if (squeeze) begin
      m_t_data_o     = core_t_data_i;
      m_t_keep_o     = core_t_keep_i;
      m_t_last_o     = core_t_last_i;
      core_t_ready_o = m_t_ready_i[owner_q];
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    keccak_arb_lane u_lane (
      .sel            (owner_q == OW'(i)),
      .absorb         (absorb),
      .squeeze        (squeeze),
      .core_t_ready_i (core_t_ready_i),
      .core_t_valid_i (core_t_valid_i),
      .s_t_ready_o    (s_t_ready_o[i]),
      .m_t_valid_o    (m_t_valid_o[i])
    );
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed-sequence bench for keccak_arbiter with randomized data. The bench
// plays both the requesters and the core; expected owners come from a
// round-robin pointer kept here, expected data from what the bench drove.

module tb_keccak_arbiter;
  import keccak_pkg::*;

  localparam int N  = 4;
  localparam int DW = DWIDTH;
  localparam int KW = KEEP_WIDTH;
  localparam int MW = MODE_SEL_WIDTH;
  localparam int OD = MAX_OUTPUT_DWIDTH;

  logic clk, rst;
  logic [N-1:0]    req_i, req_stop_i, grant_o;
  logic [N*MW-1:0] req_mode_i;
  logic [N*DW-1:0] s_t_data_i;
  logic [N*KW-1:0] s_t_keep_i;
  logic [N-1:0]    s_t_valid_i, s_t_last_i, s_t_ready_o;
  logic [OD-1:0]   m_t_data_o;
  logic [KW-1:0]   m_t_keep_o;
  logic            m_t_last_o;
  logic [N-1:0]    m_t_valid_o, m_t_ready_i;
  logic            core_start_o, core_stop_o;
  logic [MW-1:0]   core_mode_o;
  logic [DW-1:0]   core_t_data_o;
  logic [KW-1:0]   core_t_keep_o;
  logic            core_t_valid_o, core_t_last_o, core_t_ready_i;
  logic [OD-1:0]   core_t_data_i;
  logic [KW-1:0]   core_t_keep_i;
  logic            core_t_valid_i, core_t_last_i, core_t_ready_o;
  logic            busy_o;
  logic [1:0]      owner_o;

  keccak_arbiter #(.NUM_REQ(N), .STOP_HOLD(128)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .req_mode_i(req_mode_i), .req_stop_i(req_stop_i), .grant_o(grant_o),
    .s_t_data_i(s_t_data_i), .s_t_keep_i(s_t_keep_i), .s_t_valid_i(s_t_valid_i),
    .s_t_last_i(s_t_last_i), .s_t_ready_o(s_t_ready_o),
    .m_t_data_o(m_t_data_o), .m_t_keep_o(m_t_keep_o), .m_t_last_o(m_t_last_o),
    .m_t_valid_o(m_t_valid_o), .m_t_ready_i(m_t_ready_i),
    .core_start_o(core_start_o), .core_mode_o(core_mode_o), .core_stop_o(core_stop_o),
    .core_t_data_o(core_t_data_o), .core_t_keep_o(core_t_keep_o),
    .core_t_valid_o(core_t_valid_o), .core_t_last_o(core_t_last_o),
    .core_t_ready_i(core_t_ready_i),
    .core_t_data_i(core_t_data_i), .core_t_keep_i(core_t_keep_i),
    .core_t_valid_i(core_t_valid_i), .core_t_last_i(core_t_last_i),
    .core_t_ready_o(core_t_ready_o),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int rr = 0;
  logic [MW-1:0] modes [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first requester at or after rr, wrapping.
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  task automatic zero_outs(input string ctx);
    chk({ctx, "_grant"}, 64'(grant_o), 0);
    chk({ctx, "_busy"}, 64'(busy_o), 0);
    chk({ctx, "_owner"}, 64'(owner_o), 0);
    chk({ctx, "_start"}, 64'(core_start_o), 0);
    chk({ctx, "_mode"}, 64'(core_mode_o), 0);
    chk({ctx, "_stop"}, 64'(core_stop_o), 0);
    chk({ctx, "_cvalid"}, 64'(core_t_valid_o), 0);
    chk({ctx, "_clast"}, 64'(core_t_last_o), 0);
    chk({ctx, "_cdata"}, 64'(core_t_data_o), 0);
    chk({ctx, "_sready"}, 64'(s_t_ready_o), 0);
    chk({ctx, "_mvalid"}, 64'(m_t_valid_o), 0);
    chk({ctx, "_mlast"}, 64'(m_t_last_o), 0);
    chk({ctx, "_mdata"}, 64'(m_t_data_o), 0);
    chk({ctx, "_cready"}, 64'(core_t_ready_o), 0);
  endtask

  // One complete job. Starts in an IDLE cycle, ends in the following IDLE cycle.
  task automatic do_job(input logic [N-1:0] reqv, input int nin, input int nout,
                        input int stop_at, input int bp_at, input int bp_len,
                        input logic [N-1:0] noise);
    int ex, tries, bpc, nstop;
    logic [N-1:0] oh, nz;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic rdy, mr, acc, stopped;
    ex = pick(reqv);
    oh = N'(1) << ex;
    nz = noise & ~oh;
    stopped = 1'b0;
    for (int i = 0; i < N; i++) begin
      modes[i] = MW'($urandom);
      req_mode_i[i*MW +: MW] = modes[i];
    end
    req_i = reqv;
    cyc();
    chk("start_grant", 64'(grant_o), 64'(oh));
    chk("start_pulse", 64'(core_start_o), 1);
    chk("start_owner", 64'(owner_o), 64'(ex));
    chk("start_mode", 64'(core_mode_o), 64'(modes[ex]));
    chk("start_busy", 64'(busy_o), 1);
    // Non-owner noise plus an owner stop that must be ignored before squeeze.
    s_t_valid_i = nz;
    s_t_last_i  = nz;
    req_stop_i  = nz | ((nz != 0) ? oh : '0);
    cyc();
    chk("start_once", 64'(core_start_o), 0);
    chk("absorb_grant", 64'(grant_o), 64'(oh));
    for (int b = 0; b < nin; b++) begin
      d = {$urandom, $urandom};
      k = KW'($urandom);
      s_t_data_i[ex*DW +: DW] = d;
      s_t_keep_i[ex*KW +: KW] = k;
      s_t_valid_i = nz | oh;
      s_t_last_i  = nz | ((b == nin - 1) ? oh : '0);
      tries = 0;
      do begin
        rdy = (tries >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        core_t_ready_i = rdy;
        #1;
        chk("abs_data", 64'(core_t_data_o), 64'(d));
        chk("abs_keep", 64'(core_t_keep_o), 64'(k));
        chk("abs_valid", 64'(core_t_valid_o), 1);
        chk("abs_last", 64'(core_t_last_o), 64'(b == nin - 1));
        chk("abs_sready", 64'(s_t_ready_o), rdy ? 64'(oh) : 0);
        chk("abs_cready_o", 64'(core_t_ready_o), 0);
        chk("abs_stop", 64'(core_stop_o), 0);
        cyc();
        tries++;
      end while (!rdy);
    end
    s_t_valid_i = nz;
    s_t_last_i  = nz;
    core_t_ready_i = 1'b0;
    req_stop_i  = nz;
    #1;
    chk("sq_cvalid", 64'(core_t_valid_o), 0);
    chk("sq_sready", 64'(s_t_ready_o), 0);
    for (int o = 0; o < nout && !stopped; o++) begin
      d = {$urandom, $urandom};
      k = KW'($urandom);
      core_t_data_i  = d;
      core_t_keep_i  = k;
      core_t_valid_i = 1'b1;
      core_t_last_i  = (o == nout - 1);
      bpc = 0;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        mr = !(o == bp_at && bpc < bp_len);
        if (!mr) bpc++;
        m_t_ready_i = (N'($urandom) & ~oh) | (mr ? oh : '0);
        req_stop_i  = nz | ((o == stop_at && mr) ? oh : '0);
        #1;
        chk("sq_mvalid", 64'(m_t_valid_o), 64'(oh));
        chk("sq_mdata", 64'(m_t_data_o), 64'(d));
        chk("sq_mkeep", 64'(m_t_keep_o), 64'(k));
        chk("sq_mlast", 64'(m_t_last_o), 64'(o == nout - 1));
        chk("sq_cready_o", 64'(core_t_ready_o), 64'(mr));
        chk("sq_stop", 64'(core_stop_o), 0);
        chk("sq_grant", 64'(grant_o), 64'(oh));
        cyc();
        acc = mr;
      end
      chk("sq_beat_accepted", 64'(acc), 1);
      if (o == stop_at) stopped = 1'b1;
    end
    req_stop_i = nz;
    if (stopped) begin
      // Core keeps offering output; all of it must be discarded.
      core_t_valid_i = 1'b1;
      nstop = 0;
      while (core_stop_o === 1'b1 && nstop < 300) begin
        chk("stop_mvalid", 64'(m_t_valid_o), 0);
        chk("stop_cready_o", 64'(core_t_ready_o), 1);
        nstop++;
        cyc();
      end
      chk("stop_len", 64'(nstop), 128);
    end
    core_t_valid_i = 1'b1;
    #1;
    chk("rel_grant", 64'(grant_o), 64'(oh));
    chk("rel_busy", 64'(busy_o), 1);
    chk("rel_stop", 64'(core_stop_o), 0);
    chk("rel_cready_o", 64'(core_t_ready_o), 0);
    chk("rel_mvalid", 64'(m_t_valid_o), 0);
    core_t_valid_i = 1'b0;
    core_t_last_i  = 1'b0;
    s_t_valid_i    = '0;
    s_t_last_i     = '0;
    req_stop_i     = '0;
    m_t_ready_i    = '0;
    cyc();
    chk("idle_grant", 64'(grant_o), 0);
    chk("idle_busy", 64'(busy_o), 0);
    rr = (ex + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_i = '0; req_mode_i = '0; req_stop_i = '0;
    s_t_data_i = '0; s_t_keep_i = '0; s_t_valid_i = '0; s_t_last_i = '0;
    m_t_ready_i = '0; core_t_ready_i = 1'b0;
    core_t_data_i = '0; core_t_keep_i = '0; core_t_valid_i = 1'b0; core_t_last_i = 1'b0;
    #2 rst = 1'b1;
    repeat (2) cyc();
    zero_outs("reset");
    @(negedge clk) rst = 1'b0;
    cyc();
    zero_outs("post_reset");

    // Single job from requester 2, one beat in, two digest beats out.
    do_job(4'b0100, 1, 2, -1, -1, 0, '0);
    req_i = '0;
    repeat (2) cyc();
    chk("idle_hold_grant", 64'(grant_o), 0);
    // Pointer should now sit at 3: requester 3 beats 0 and 1.
    do_job(4'b1011, 2, 1, -1, -1, 0, '0);

    // Constant full contention: 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      chk("rr_order_model", 64'(pick(4'b1111)), 64'(j % N));
      do_job(4'b1111, 1 + (j % 3), 1 + (j % 2), -1, -1, 0, '0);
    end

    // Backpressure mid-digest for 10 cycles.
    req_i = '0;
    cyc();
    do_job(4'b0010, 2, 4, -1, 2, 10, '0);

    // Stop after two digest beats, then next requester granted.
    do_job(4'b1111, 1, 6, 2, -1, 0, '0);
    do_job(4'b1111, 1, 1, -1, -1, 0, '0);

    // Isolation: non-owners drive valid/last/stop throughout the job.
    req_i = '0;
    cyc();
    do_job(4'b0001, 3, 3, -1, 1, 3, 4'b1111);

    // Reset mid-absorb.
    req_i = 4'b1111;
    cyc();
    req_i = '0;
    cyc();
    s_t_valid_i = 4'b1111;
    s_t_last_i  = '0;
    s_t_data_i  = {N{64'hdead_beef_cafe_f00d}};
    core_t_ready_i = 1'b1;
    #1;
    chk("pre_rst_cvalid", 64'(core_t_valid_o), 1);
    rst = 1'b1;
    #1;
    zero_outs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    s_t_valid_i = '0;
    core_t_ready_i = 1'b0;
    rr = 0;
    cyc();
    chk("post_rst_busy", 64'(busy_o), 0);
    do_job(4'b0010, 1, 1, -1, -1, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
